// File: rtl/hash_encoding.sv
// Shared encodings for the interpolation scheduler: FSM state type and
// default engine timeout.
package hash_encoding;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } sched_state_t;

    localparam int DEFAULT_TIMEOUT = 64;
    localparam int WAIT_CNT_W      = 7;

endpackage

// File: rtl/rr_arb.sv
// Round-robin picker: selects the first asserted request at or after ptr,
// wrapping modulo N.
module rr_arb #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    output logic            gnt_vld,
    output logic [ID_W-1:0] gnt_idx,
    output logic [N-1:0]    gnt_oh
);

    logic [ID_W-1:0] cand;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        gnt_oh  = '0;
        cand    = '0;
        for (int i = 0; i < N; i++) begin
            cand = ID_W'((int'(ptr) + i) % N);
            if (!gnt_vld && req[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_vld) gnt_oh[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/interp_sched.sv
// Schedules NUM_REQ requesters onto one trilinear interpolation engine,
// one operation in flight, with round-robin grant and engine timeout.
module interp_sched
    import hash_encoding::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 32,
    parameter int TAG_W     = 8,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*TAG_W-1:0]   req_tag,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       eng_en,
    output logic [$clog2(NUM_REQ)-1:0] eng_sel,
    input  logic                       eng_done,
    input  logic [DATA_SIZE-1:0]       eng_feat,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [TAG_W-1:0]           rsp_tag,
    output logic [DATA_SIZE-1:0]       rsp_data,
    output logic                       rsp_err,
    output logic                       err_timeout,
    output logic                       busy,
    output logic [15:0]                done_cnt
);

    localparam int ID_W = $clog2(NUM_REQ);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(TIMEOUT - 1);
    localparam logic [ID_W-1:0]       ID_LAST   = ID_W'(NUM_REQ - 1);

    sched_state_t          state, state_nxt;
    logic [ID_W-1:0]       rr_ptr;
    logic [ID_W-1:0]       cur_id;
    logic [TAG_W-1:0]      cur_tag;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  gnt_vld;
    logic [ID_W-1:0]       gnt_idx;
    logic [NUM_REQ-1:0]    gnt_oh;
    logic [TAG_W-1:0]      gnt_tag;
    logic                  wait_expired;

    rr_arb #(.N(NUM_REQ), .ID_W(ID_W)) u_rr_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx),
        .gnt_oh  (gnt_oh)
    );

    always_comb begin
        gnt_tag = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == ID_W'(i)) gnt_tag = req_tag[i*TAG_W +: TAG_W];
        end
    end

    assign wait_expired = (wait_cnt == WAIT_LAST);

    // NOTE: sequential state uses non-blocking assignments and a synchronous reset sampled on clk.
    always_ff @(posedge clk) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (gnt_vld) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (eng_done || wait_expired) state_nxt = ST_RESP;
            ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            rr_ptr      <= '0;
            cur_id      <= '0;
            cur_tag     <= '0;
            wait_cnt    <= '0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            err_timeout <= 1'b0;
            done_cnt    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        cur_id  <= gnt_idx;
                        cur_tag <= gnt_tag;
                    end
                end
                ST_ISSUE: wait_cnt <= '0;
                ST_WAIT: begin
                    wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
                    // A completion in the final WAIT cycle beats the timeout.
                    if (eng_done) begin
                        rsp_data <= eng_feat;
                        rsp_err  <= 1'b0;
                    end else if (wait_expired) begin
                        rsp_data    <= '0;
                        rsp_err     <= 1'b1;
                        err_timeout <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rr_ptr   <= (cur_id == ID_LAST) ? '0 : cur_id + ID_W'(1);
                        done_cnt <= done_cnt + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // The engine reads operands through eng_sel for the whole operation.
    assign req_ready = (state == ST_IDLE) ? gnt_oh : '0;
    assign eng_en    = (state == ST_ISSUE);
    assign eng_sel   = cur_id;
    assign rsp_valid = (state == ST_RESP);
    assign rsp_id    = cur_id;
    assign rsp_tag   = cur_tag;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_interp_sched.sv
// Self-checking bench for interp_sched: directed vector table, reset-abort
// sequence and randomized transactions against a transaction-level model.
module tb_interp_sched;

    localparam int N   = 4;
    localparam int DW  = 32;
    localparam int TW  = 8;
    localparam int TO  = 64;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req_valid;
    logic [N*TW-1:0] req_tag;
    logic [N-1:0]    req_ready;
    logic            eng_en;
    logic [1:0]      eng_sel;
    logic            eng_done;
    logic [DW-1:0]   eng_feat;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [TW-1:0]   rsp_tag;
    logic [DW-1:0]   rsp_data;
    logic            rsp_err;
    logic            err_timeout;
    logic            busy;
    logic [15:0]     done_cnt;

    interp_sched #(.NUM_REQ(N), .DATA_SIZE(DW), .TAG_W(TW), .TIMEOUT(TO)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .req_valid   (req_valid),
        .req_tag     (req_tag),
        .req_ready   (req_ready),
        .eng_en      (eng_en),
        .eng_sel     (eng_sel),
        .eng_done    (eng_done),
        .eng_feat    (eng_feat),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_tag     (rsp_tag),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .err_timeout (err_timeout),
        .busy        (busy),
        .done_cnt    (done_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model state
    int   m_ptr    = 0;
    int   m_done   = 0;
    logic m_sticky = 1'b0;

    // Engine model: done pulse eng_lat cycles after the eng_en cycle (never if negative)
    int            eng_lat  = -1;
    logic [DW-1:0] eng_data = '0;
    int            eng_cnt  = 0;
    logic [DW-1:0] eng_pend = '0;

    initial begin
        eng_done = 1'b0;
        eng_feat = '0;
        forever begin
            @(negedge clk);
            eng_done = 1'b0;
            eng_feat = $urandom;
            if (eng_cnt > 0) begin
                eng_cnt = eng_cnt - 1;
                if (eng_cnt == 0) begin
                    eng_done = 1'b1;
                    eng_feat = eng_pend;
                end
            end
            if (eng_en === 1'b1 && eng_lat >= 0) begin
                eng_cnt  = eng_lat;
                eng_pend = eng_data;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] tags;
        int          lat;
        logic [31:0] data;
        int          hold;
        int          exp_id;
        logic        exp_err;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs[13];

    // Drives one request from an IDLE cycle through the response handshake.
    task automatic run_txn(input vec_t v);
        int          cyc;
        int          en_cnt;
        logic        seen;
        logic        sel_bad;
        logic        rdy_bad;
        logic        hold_bad;
        logic [7:0]  exp_tag;
        logic [42:0] snap;
        req_valid = v.valid;
        req_tag   = v.tags;
        eng_lat   = v.lat;
        eng_data  = v.data;
        #1;
        check("req_ready_grant", req_ready, 4'b0001 << v.exp_id);
        exp_tag  = v.tags[v.exp_id*8 +: 8];
        cyc      = 0;
        en_cnt   = 0;
        seen     = 1'b0;
        sel_bad  = 1'b0;
        rdy_bad  = 1'b0;
        while (!seen && cyc < 200) begin
            tick();
            cyc++;
            if (rsp_valid) seen = 1'b1;
            else begin
                if (eng_en) en_cnt++;
                if (eng_sel != 2'(v.exp_id)) sel_bad = 1'b1;
                if (req_ready != '0) rdy_bad = 1'b1;
            end
        end
        check("rsp_valid_seen", seen, 1'b1);
        check("grant_to_rsp_latency", cyc, v.exp_lat);
        check("eng_en_pulses", en_cnt, 1);
        check("eng_sel_stable_bad", sel_bad, 1'b0);
        check("req_ready_busy_bad", rdy_bad, 1'b0);
        check("rsp_id", rsp_id, v.exp_id);
        check("rsp_tag", rsp_tag, exp_tag);
        check("rsp_data", rsp_data, v.exp_data);
        check("rsp_err", rsp_err, v.exp_err);
        m_sticky = m_sticky | v.exp_err;
        check("err_timeout", err_timeout, m_sticky);
        if (v.hold > 0) begin
            snap     = {rsp_id, rsp_tag, rsp_data, rsp_err};
            hold_bad = 1'b0;
            repeat (v.hold) begin
                tick();
                if (!rsp_valid || snap != {rsp_id, rsp_tag, rsp_data, rsp_err} ||
                    req_ready != '0 || eng_en) hold_bad = 1'b1;
            end
            check("rsp_hold_stable_bad", hold_bad, 1'b0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        m_done++;
        m_ptr = (v.exp_id + 1) % N;
        check("done_cnt", done_cnt, 16'(m_done));
        check("idle_after_handshake", {rsp_valid, busy}, 2'b00);
    endtask

    // Reference model: round-robin pick plus done-or-timeout outcome.
    function automatic vec_t model_vec(input logic [3:0] valid, input logic [31:0] tags,
                                       input int lat, input logic [31:0] data, input int hold);
        vec_t v;
        v.valid  = valid;
        v.tags   = tags;
        v.lat    = lat;
        v.data   = data;
        v.hold   = hold;
        v.exp_id = -1;
        for (int i = 0; i < N; i++) begin
            int j;
            j = (m_ptr + i) % N;
            if (v.exp_id < 0 && valid[j]) v.exp_id = j;
        end
        if (lat >= 1 && lat <= TO) begin
            v.exp_err  = 1'b0;
            v.exp_data = data;
            v.exp_lat  = 2 + lat;
        end else begin
            v.exp_err  = 1'b1;
            v.exp_data = '0;
            v.exp_lat  = 2 + TO;
        end
        return v;
    endfunction

    initial begin
        int   bad;
        vec_t rv;
        int   r;

        vecs[0]  = '{4'b1111, 32'h13121110,  5, 32'h000000A0,  0, 0, 1'b0, 32'h000000A0,  7};
        vecs[1]  = '{4'b1111, 32'h13121110,  6, 32'h000000A1,  0, 1, 1'b0, 32'h000000A1,  8};
        vecs[2]  = '{4'b1111, 32'h13121110,  7, 32'h000000A2,  0, 2, 1'b0, 32'h000000A2,  9};
        vecs[3]  = '{4'b1111, 32'h13121110,  8, 32'h000000A3,  0, 3, 1'b0, 32'h000000A3, 10};
        vecs[4]  = '{4'b1111, 32'h13121110,  9, 32'h000000A4,  0, 0, 1'b0, 32'h000000A4, 11};
        vecs[5]  = '{4'b0001, 32'h0000005A, 13, 32'h3F800000,  0, 0, 1'b0, 32'h3F800000, 15};
        vecs[6]  = '{4'b0100, 32'h00770000, -1, 32'h11111111,  0, 2, 1'b1, 32'h00000000, 66};
        vecs[7]  = '{4'b1000, 32'h42000000,  3, 32'hDEADBEEF,  0, 3, 1'b0, 32'hDEADBEEF,  5};
        vecs[8]  = '{4'b0010, 32'h00003300,  4, 32'hCAFEF00D, 10, 1, 1'b0, 32'hCAFEF00D,  6};
        vecs[9]  = '{4'b0001, 32'h00000001, 64, 32'h12345678,  0, 0, 1'b0, 32'h12345678, 66};
        vecs[10] = '{4'b0100, 32'h00990000, 65, 32'h55AA55AA,  0, 2, 1'b1, 32'h00000000, 66};
        vecs[11] = '{4'b0011, 32'h0000BBAA,  2, 32'h00000001,  2, 0, 1'b0, 32'h00000001,  4};
        vecs[12] = '{4'b0011, 32'h0000BBAA,  2, 32'h00000002,  0, 1, 1'b0, 32'h00000002,  4};

        rstn      = 1'b0;
        req_valid = '0;
        req_tag   = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        check("reset_outputs", {rsp_valid, rsp_data, rsp_err, err_timeout, eng_en, eng_sel,
                                req_ready, busy, rsp_id, rsp_tag}, '0);
        check("reset_done_cnt", done_cnt, 16'd0);
        rstn = 1'b1;
        tick();

        for (int k = 0; k < 13; k++) run_txn(vecs[k]);

        // Abort an operation mid-WAIT; its late completion must not produce a response.
        req_valid = 4'b0100;
        req_tag   = 32'h00660000;
        eng_lat   = 20;
        eng_data  = 32'hBADC0DE0;
        repeat (4) tick();
        check("busy_before_abort", busy, 1'b1);
        rstn      = 1'b0;
        req_valid = '0;
        tick();
        rstn = 1'b1;
        check("abort_outputs_zero", {rsp_valid, rsp_data, rsp_err, err_timeout, eng_en, eng_sel,
                                     req_ready, busy, rsp_id, rsp_tag}, '0);
        check("abort_done_cnt", done_cnt, 16'd0);
        m_ptr = 0; m_done = 0; m_sticky = 1'b0;
        bad = 0;
        repeat (30) begin
            tick();
            if (rsp_valid || eng_en || busy || err_timeout) bad++;
        end
        check("late_eng_done_ignored", bad, 0);

        for (int k = 0; k < 40; k++) begin
            r  = $urandom_range(0, 7);
            rv = model_vec(4'($urandom_range(1, 15)), $urandom,
                           (r == 0) ? $urandom_range(65, 80) : $urandom_range(1, 64),
                           $urandom, $urandom_range(0, 3));
            run_txn(rv);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
